// File: rtl/db_uart_rx.sv
// Debug UART receiver: 16x-oversampled 8N1 capture behind a two-flop synchroniser,
// buffered in a small FIFO with a valid/ready output and framing/overrun pulses.
module db_uart_rx #(
    parameter int unsigned CLKS_PER_TICK = 27,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned TickW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam int unsigned PtrW  = AddrW + 1;
    localparam logic [TickW-1:0] TickMax = TickW'(CLKS_PER_TICK - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    // Synchroniser and tick generator
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             rxs;
    logic [TickW-1:0] tcnt_q, tcnt_d;
    logic             tick;

    // Receiver FSM
    state_e      state_q, state_d;
    logic [3:0]  scnt_q, scnt_d;
    logic [2:0]  bidx_q, bidx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        busy_q, busy_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        good_frame;

    // Receive FIFO
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;

    always_comb begin
        sync1_d = rxd;
        sync2_d = sync1_q;
        rxs     = sync2_q;
        tick    = (tcnt_q == TickMax);
        tcnt_d  = tick ? '0 : tcnt_q + TickW'(1);
    end

    always_comb begin
        state_d     = state_q;
        scnt_d      = scnt_q;
        bidx_d      = bidx_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        good_frame  = 1'b0;

        if (tick) begin
            case (state_q)
                StIdle: begin
                    if (!rxs) begin
                        state_d = StStart;
                        scnt_d  = 4'd0;
                    end
                end
                StStart: begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd7) begin
                        // Mid start bit: a line already back high was only a glitch.
                        if (!rxs) begin
                            state_d = StData;
                            scnt_d  = 4'd0;
                            bidx_d  = 3'd0;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StData: begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        shreg_d = {rxs, shreg_q[7:1]};
                        bidx_d  = bidx_q + 3'd1;
                        if (bidx_q == 3'd7) begin
                            state_d = StStop;
                            scnt_d  = 4'd0;
                        end
                    end
                end
                StStop: begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        if (rxs) begin
                            good_frame = 1'b1;
                            state_d    = StIdle;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = StWaitHigh;
                        end
                    end
                end
                StWaitHigh: begin
                    // Hold off until the line idles so a break cannot restart reception.
                    if (rxs) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
        rx_valid = !empty;
        rx_data  = mem_q[rd_ptr_q[AddrW-1:0]];
        pop      = rx_valid && rx_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
        push      = good_frame && (!full || pop);
        overrun_d = good_frame && full && !pop;

        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AddrW-1:0]] = shreg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            tcnt_q      <= '0;
            state_q     <= StIdle;
            scnt_q      <= 4'd0;
            bidx_q      <= 3'd0;
            shreg_q     <= 8'h00;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_q       <= '{default: 8'h00};
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            tcnt_q      <= tcnt_d;
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            bidx_q      <= bidx_d;
            shreg_q     <= shreg_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
        end
    end

    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_db_uart_rx.sv
// Bench for db_uart_rx: table vectors, directed corner sequences and random frames
// checked against a byte-queue model of the receive FIFO.
module tb_db_uart_rx;

    localparam int Depth = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    db_uart_rx #(
        .CLKS_PER_TICK(1),
        .FIFO_DEPTH   (Depth)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fails = 0;
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    int         exp_ovr = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    int         pop_cnt = 0;
    logic [7:0] last_pop = 8'h00;
    bit         rand_ready = 1'b0;

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         gap;
        bit         exp_pop;
        logic [7:0] exp_byte;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: counts flag pulses and checks every pop against the model queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (frame_err || overrun) check("flag_exclusive", {31'd0, frame_err & overrun}, 0);
            if (rx_valid && rx_ready) begin
                pop_cnt++;
                last_pop = rx_data;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no data", rx_data);
                end else begin
                    check("pop_data", rx_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ready(input int ready_pulse, input int c);
        if (ready_pulse >= 0) rx_ready = (c == ready_pulse);
        else if (rand_ready) rx_ready = ($urandom_range(0, 7) == 0);
    endtask

    // Drives ncyc cycles of an 8N1 frame (160 for a full one). The model decides the
    // frame's fate right after the edge on which the stop bit is sampled.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int ready_pulse,
                              input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            if (c < 16) rxd = 1'b0;
            else if (c < 144) rxd = b[(c - 16) / 16];
            else rxd = stop_ok;
            drive_ready(ready_pulse, c);
            step();
            if (c == 154) begin
                if (!stop_ok) exp_ferr++;
                else if (exp_q.size() < Depth) exp_q.push_back(b);
                else exp_ovr++;
            end
        end
        rxd = 1'b1;
        if (ready_pulse >= 0) rx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        for (int c = 0; c < n; c++) begin
            drive_ready(-1, c);
            step();
        end
    endtask

    task automatic drain(input string name);
        rx_ready = 1'b1;
        for (int k = 0; k < Depth + 4 && rx_valid; k++) step();
        rx_ready = 1'b0;
        check(name, {31'd0, rx_valid}, 0);
    endtask

    task automatic wait_busy(input logic val, input int budget, input string name);
        for (int k = 0; k < budget && busy !== val; k++) step();
        check(name, {31'd0, busy}, {31'd0, val});
    endtask

    task automatic check_totals(input string tag);
        check({tag, "_ferr_total"}, ferr_cnt, exp_ferr);
        check({tag, "_ovr_total"}, ovr_cnt, exp_ovr);
        check({tag, "_model_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, f0, o0;

        vecs[0] = '{8'h00, 1'b1, 4,  1'b1, 8'h00, 0};
        vecs[1] = '{8'hFF, 1'b1, 0,  1'b1, 8'hFF, 0};
        vecs[2] = '{8'hA5, 1'b0, 20, 1'b0, 8'h00, 1};
        vecs[3] = '{8'h5A, 1'b1, 2,  1'b1, 8'h5A, 0};
        vecs[4] = '{8'h80, 1'b1, 0,  1'b1, 8'h80, 0};
        vecs[5] = '{8'h01, 1'b0, 16, 1'b0, 8'h00, 1};

        // Reset state
        reset = 1'b1;
        repeat (3) step();
        check("rst_valid", {31'd0, rx_valid}, 0);
        check("rst_data", rx_data, 8'h00);
        check("rst_ferr", {31'd0, frame_err}, 0);
        check("rst_ovr", {31'd0, overrun}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        reset = 1'b0;
        idle(4);

        // 0x55 held at the head until accepted
        send_frame(8'h55, 1'b1, -1, 160);
        idle(20);
        check("t1_valid", {31'd0, rx_valid}, 1);
        check("t1_data", rx_data, 8'h55);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        check("t1_valid_after_pop", {31'd0, rx_valid}, 0);
        check_totals("t1");

        // Short low glitch is rejected
        p0 = pop_cnt;
        rxd = 1'b0;
        repeat (4) step();
        rxd = 1'b1;
        wait_busy(1'b1, 8, "t2_busy_rise");
        wait_busy(1'b0, 16, "t2_busy_fall");
        idle(4);
        check("t2_valid", {31'd0, rx_valid}, 0);
        check("t2_pops", pop_cnt - p0, 0);
        check_totals("t2");

        // Framing error, then a good frame as the sole entry
        f0 = ferr_cnt;
        send_frame(8'hA3, 1'b0, -1, 160);
        idle(20);
        send_frame(8'h3C, 1'b1, -1, 160);
        idle(4);
        check("t3_ferr_pulses", ferr_cnt - f0, 1);
        check("t3_valid", {31'd0, rx_valid}, 1);
        check("t3_data", rx_data, 8'h3C);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        check("t3_single_entry", {31'd0, rx_valid}, 0);
        check_totals("t3");

        // Overrun on the fifth byte into a full FIFO
        o0 = ovr_cnt;
        p0 = pop_cnt;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, -1, 160);
        check("t4_no_early_ovr", ovr_cnt - o0, 0);
        send_frame(8'h05, 1'b1, -1, 160);
        check("t4_ovr_pulses", ovr_cnt - o0, 1);
        drain("t4_drained");
        check("t4_pops", pop_cnt - p0, 4);
        check_totals("t4");

        // Reset in the middle of data bit 4 with a byte already queued
        send_frame(8'h77, 1'b1, -1, 160);
        send_frame(8'h96, 1'b1, -1, 88);
        check("t5_busy_mid", {31'd0, busy}, 1);
        reset = 1'b1;
        rxd = 1'b1;
        step();
        check("t5_busy_rst", {31'd0, busy}, 0);
        check("t5_valid_rst", {31'd0, rx_valid}, 0);
        check("t5_data_rst", rx_data, 8'h00);
        reset = 1'b0;
        exp_q.delete();
        idle(4);
        p0 = pop_cnt;
        rx_ready = 1'b1;
        send_frame(8'h81, 1'b1, -1, 160);
        idle(4);
        rx_ready = 1'b0;
        check("t5_pops", pop_cnt - p0, 1);
        check("t5_data", last_pop, 8'h81);
        check_totals("t5");

        // Back-to-back frames, then a pop on the very cycle a full FIFO takes a push
        p0 = pop_cnt;
        o0 = ovr_cnt;
        rx_ready = 1'b1;
        send_frame(8'h00, 1'b1, -1, 160);
        send_frame(8'hFF, 1'b1, -1, 160);
        idle(4);
        rx_ready = 1'b0;
        check("t6_b2b_pops", pop_cnt - p0, 2);
        check("t6_b2b_last", last_pop, 8'hFF);
        p0 = pop_cnt;
        for (int i = 1; i <= 4; i++) send_frame(8'(i * 17), 1'b1, -1, 160);
        send_frame(8'h5A, 1'b1, 154, 160);
        check("t6_no_ovr", ovr_cnt - o0, 0);
        drain("t6_drained");
        check("t6_pops", pop_cnt - p0, 5);
        check("t6_last", last_pop, 8'h5A);
        check_totals("t6");

        // Table vectors, consumer always ready
        rx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            p0 = pop_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop_ok, -1, 160);
            idle(vecs[i].gap);
            check($sformatf("vec%0d_pops", i), pop_cnt - p0, {31'd0, vecs[i].exp_pop});
            if (vecs[i].exp_pop) check($sformatf("vec%0d_byte", i), last_pop, vecs[i].exp_byte);
            check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
        end
        rx_ready = 1'b0;
        check_totals("vec");

        // Random frames with a sparse random consumer
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bit ok;
            ok = ($urandom_range(0, 4) != 0);
            send_frame(8'($urandom_range(0, 255)), ok, -1, 160);
            idle(ok ? $urandom_range(0, 10) : $urandom_range(16, 30));
        end
        rand_ready = 1'b0;
        drain("rand_drained");
        check_totals("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/db_uart_rx.md
Name: db_uart_rx

Overview:
- Debug serial receiver sitting directly behind the SoC `db_rxd` pin and ahead of the debugger command parser.
- Oversamples the asynchronous line at 16x the baud rate, validates the start bit and recovers 8N1 frames LSB-first.
- Buffers received bytes in a small FIFO and presents them on a valid/ready interface.
- Reports framing errors and FIFO overruns to the debugger as single-cycle pulses.

Parameters:
- CLKS_PER_TICK, 27, clk cycles per 16x oversample tick (27 gives ≈115200 baud at 50 MHz). Must be ≥1.
- FIFO_DEPTH, 4, receive FIFO entries. Must be a power of 2 and ≥2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rxd  in  1  asynchronous serial input; idles high
- rx_data  out  8  byte at the FIFO head
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer accepts `rx_data` this cycle
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: good frame dropped because the FIFO was full
- busy  out  1  receiver FSM not in IDLE

Behaviour:
- Interface: one clock (`clk`). Reset is synchronous and active-high (`reset`).
- Reset values:
  - `rx_valid`=0, `rx_data`=0x00, `frame_err`=0, `overrun`=0, `busy`=0.
  - FIFO empty; FSM in IDLE; tick counter 0.
  - Both synchroniser flops =1, so no false start follows reset.
- Synchroniser: `rxd` passes through 2 flops; `rxs` is the second flop's output. All decisions use `rxs` only.
- Tick generator:
  - Free-running counter 0..CLKS_PER_TICK-1.
  - `tick`=1 in the cycle the counter equals CLKS_PER_TICK-1, then the counter wraps to 0.
  - With CLKS_PER_TICK=1, `tick` is high every cycle.
- FSM state changes and sample decisions occur only on `tick` cycles. `scnt` is a 4-bit sample counter; `bidx` is a 3-bit bit index.
  - IDLE: `rxs`=0 → START, `scnt`=0.
  - START:
    - `scnt`++.
    - When `scnt`==7 (mid start bit): `rxs`=0 → DATA with `scnt`=0, `bidx`=0; `rxs`=1 → IDLE (glitch rejected, no flags).
  - DATA:
    - `scnt`++.
    - When `scnt`==15: shift register ← {`rxs`, shreg[7:1]} (LSB first) and `bidx`++.
    - When `bidx` was 7 at that sample → STOP with `scnt`=0.
  - STOP:
    - `scnt`++.
    - When `scnt`==15, if `rxs`=1 (good frame):
      - FIFO not full, or full with a pop in the same cycle → push the shift register.
      - Otherwise drop the byte and pulse `overrun`.
      - Go to IDLE.
    - When `scnt`==15, if `rxs`=0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: `rxs`=1 → IDLE (prevents a break condition re-triggering reception).
- `busy` = (state != IDLE), registered together with the state.
- FIFO:
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits; full/empty is decided by comparing the MSBs.
  - `rx_valid` = !empty. `rx_data` = mem[rd_ptr] and is stable while `rx_valid`=1 and `rx_ready`=0.
  - Pop occurs when `rx_valid` && `rx_ready`; pointers wrap modulo 2×FIFO_DEPTH.
  - Push and pop in the same cycle leave the count unchanged. This also applies when full, in which case the push is accepted.
  - `rx_ready` while empty is ignored.
  - Latency: a byte pushed at edge N gives `rx_valid`=1 at edge N when the FIFO was empty (visible in the following cycle).
- `frame_err` and `overrun` are high for exactly one `clk` cycle per event, never both for the same frame.
- Reset mid-frame: abandon the frame, empty the FIFO, return to IDLE. The next full frame after reset deasserts is received correctly.

Test Plan:
All tests use CLKS_PER_TICK=1 (16 clk per bit) and FIFO_DEPTH=4.
1. Send 0x55 8N1 with `rx_ready`=0 → `rx_valid`=1, `rx_data`=0x55 held until `rx_ready`=1, then `rx_valid`=0. `frame_err`=`overrun`=0.
2. Drive `rxd` low for 4 clk, then high → `busy` rises then returns to 0 by START `scnt`==7. No push, no flags.
3. Send 0xA3 with stop bit low for 16 clk, then idle high, then 0x3C:
   - One `frame_err` pulse; 0xA3 is not in the FIFO.
   - 0x3C is received as the only FIFO entry.
4. With `rx_ready`=0, send 0x01, 0x02, 0x03, 0x04, 0x05:
   - Exactly one `overrun` pulse, at the 0x05 stop sample.
   - Draining yields 0x01..0x04 in order, then `rx_valid`=0.
5. Assert `reset` during data bit 4 of a frame → next cycle `busy`=0, `rx_valid`=0. After release, send 0x81 → 0x81 received, no flags.
6. With `rx_ready`=1, send 0x00 and 0xFF back-to-back (1 stop bit each) → both received in order. Also pop while full at the instant a 5th byte (0x5A) completes → 0x5A accepted, no `overrun`.
